alu_host_ctrl: RTL

ALU_HOST_CTRL -- requirements
Module: alu_host_ctrl

---
 rtl/alu_host_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/alu_host_ctrl.sv
// Host-side sequencer for an external two-set ALU: accepts one command,
// screens it, pulses the ALU, captures the result/interrupt and hands back a response.
module alu_host_ctrl #(
    parameter int AUTO_CLR = 1,
    parameter int CNT_W    = 8
) (
    input  logic             alu_clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_sel,
    input  logic [1:0]       cmd_op,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    output logic             alu_enable,
    output logic             alu_enable_a,
    output logic             alu_enable_b,
    output logic             alu_irq_clr,
    output logic [1:0]       alu_op_a,
    output logic [1:0]       alu_op_b,
    output logic [7:0]       alu_in_a,
    output logic [7:0]       alu_in_b,
    input  logic [7:0]       alu_out,
    input  logic             alu_irq,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_data,
    output logic             rsp_irq,
    output logic             rsp_err,
    output logic [CNT_W-1:0] irq_count
);

    // state     | meaning
    // IDLE      | ready for a command
    // ISSUE     | one-cycle ALU enable pulse
    // CAPTURE   | register ALU result and interrupt
    // IRQCLR    | one-cycle interrupt clear pulse
    // RESP      | response held until rsp_ready
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_CAPTURE = 3'd2,
        S_IRQCLR  = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    logic             r_sel;
    logic [7:0]       r_alu_in_a;
    logic [7:0]       r_alu_in_b;
    logic [1:0]       r_alu_op_a;
    logic [1:0]       r_alu_op_b;
    logic [7:0]       r_rsp_data;
    logic             r_rsp_irq;
    logic             r_rsp_err;
    logic [CNT_W-1:0] r_irq_count;

    logic w_accept;
    logic w_illegal;
    logic w_auto_clr;

    assign w_auto_clr = (AUTO_CLR != 0);
    assign w_accept   = (r_state == S_IDLE) && cmd_valid;

    // Operand combinations the ALU cannot handle are answered without touching it.
    assign w_illegal = !cmd_sel
        ? ((cmd_op == 2'b00 && cmd_b == 8'h00) ||
           (cmd_op == 2'b01 && (cmd_a == 8'hFF || cmd_b == 8'h03)))
        : ((cmd_op == 2'b01 && cmd_b == 8'h03) ||
           (cmd_op == 2'b10 && cmd_a == 8'hF5));

    always_ff @(posedge alu_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (cmd_valid) w_next = w_illegal ? S_RESP : S_ISSUE;
            S_ISSUE:   w_next = S_CAPTURE;
            S_CAPTURE: w_next = (alu_irq && w_auto_clr) ? S_IRQCLR : S_RESP;
            S_IRQCLR:  w_next = S_RESP;
            S_RESP:    if (rsp_ready) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready    = 1'b0;
        rsp_valid    = 1'b0;
        alu_enable   = 1'b0;
        alu_enable_a = 1'b0;
        alu_enable_b = 1'b0;
        alu_irq_clr  = 1'b0;
        case (r_state)
            S_IDLE:  cmd_ready = 1'b1;
            S_ISSUE: begin
                alu_enable   = 1'b1;
                alu_enable_a = !r_sel;
                alu_enable_b = r_sel;
            end
            S_IRQCLR: alu_irq_clr = 1'b1;
            S_RESP:   rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge alu_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel       <= 1'b0;
            r_alu_in_a  <= 8'h00;
            r_alu_in_b  <= 8'h00;
            r_alu_op_a  <= 2'b00;
            r_alu_op_b  <= 2'b00;
            r_rsp_data  <= 8'h00;
            r_rsp_irq   <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_irq_count <= '0;
        end else begin
            if (w_accept) begin
                r_sel <= cmd_sel;
                if (w_illegal) begin
                    r_rsp_data <= 8'h00;
                    r_rsp_irq  <= 1'b0;
                    r_rsp_err  <= 1'b1;
                end else begin
                    // Bus values persist after ISSUE so the ALU sees stable inputs.
                    r_alu_in_a <= cmd_a;
                    r_alu_in_b <= cmd_b;
                    r_alu_op_a <= cmd_sel ? 2'b00 : cmd_op;
                    r_alu_op_b <= cmd_sel ? cmd_op : 2'b00;
                end
            end
            if (r_state == S_CAPTURE) begin
                r_rsp_data <= alu_out;
                r_rsp_irq  <= alu_irq;
                r_rsp_err  <= 1'b0;
                if (alu_irq && (r_irq_count != '1)) begin
                    r_irq_count <= r_irq_count + CNT_W'(1);
                end
            end
        end
    end

    assign alu_in_a  = r_alu_in_a;
    assign alu_in_b  = r_alu_in_b;
    assign alu_op_a  = r_alu_op_a;
    assign alu_op_b  = r_alu_op_b;
    assign rsp_data  = r_rsp_data;
    assign rsp_irq   = r_rsp_irq;
    assign rsp_err   = r_rsp_err;
    assign irq_count = r_irq_count;

endmodule
